// File: rtl/uart_bcd_parser_if.sv
// UART-side byte stream for the BCD command parser: received bytes in,
// transmit strobes out, transmitter busy back.
interface uart_bcd_parser_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  // master = UART / environment side, slave = parser
  modport master (
    output rx_ready, rx_data, tx_busy,
    input  tx_start, tx_data
  );

  modport slave (
    input  rx_ready, rx_data, tx_busy,
    output tx_start, tx_data
  );
endinterface

// File: rtl/uart_bcd_parser.sv
// Assembles ASCII decimal digits into packed BCD, commits on CR/LF, and
// echoes accepted bytes plus K/? acknowledgements through a small TX FIFO.
module uart_bcd_parser #(
  parameter int DIGITS     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_bcd_parser_if.slave      bus,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  err,
  output logic                  tx_drop
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIG_MAX  = CW'(DIGITS);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {T_IDLE, T_WAIT} tx_state_e;

  // line assembly state
  logic [W-1:0]  work_q, work_d;
  logic [CW-1:0] count_q, count_d;
  logic          bad_q, bad_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic          err_q, err_d;
  logic          push;
  logic [7:0]    push_byte;
  logic          is_digit;

  // echo FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, pop, wr_en;
  logic          tx_drop_q;

  // transmit issue
  tx_state_e     tx_state_q;
  logic          first_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;

  assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);

  always_comb begin
    work_d      = work_q;
    count_d     = count_q;
    bad_d       = bad_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    err_d       = 1'b0;
    push        = 1'b0;
    push_byte   = 8'h00;
    if (bus.rx_ready) begin
      if (is_digit) begin
        if (count_q < DIG_MAX && !bad_q) begin
          work_d    = (work_q << 4) | W'(bus.rx_data[3:0]);
          count_d   = count_q + CW'(1);
          push      = 1'b1;
          push_byte = bus.rx_data;
        end else begin
          bad_d = 1'b1;
        end
      end else begin
        case (bus.rx_data)
          8'h08: if (count_q != '0) begin
            work_d    = work_q >> 4;
            count_d   = count_q - CW'(1);
            push      = 1'b1;
            push_byte = 8'h08;
          end
          8'h1B: begin
            work_d  = '0;
            count_d = '0;
            bad_d   = 1'b0;
          end
          8'h0D, 8'h0A: begin
            // an empty clean line is silent so CR LF yields one response
            if (bad_q) begin
              err_d     = 1'b1;
              push      = 1'b1;
              push_byte = 8'h3F;
            end else if (count_q != '0) begin
              bcd_d       = work_q;
              bcd_valid_d = 1'b1;
              push        = 1'b1;
              push_byte   = 8'h4B;
            end
            work_d  = '0;
            count_d = '0;
            bad_d   = 1'b0;
          end
          default: bad_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q      <= '0;
      count_q     <= '0;
      bad_q       <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      work_q      <= work_d;
      count_q     <= count_d;
      bad_q       <= bad_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      err_q       <= err_d;
    end
  end

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pop   = (tx_state_q == T_IDLE) && !empty && !bus.tx_busy;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) tx_drop_q <= 1'b1;
    end
  end

  // T_WAIT ignores tx_busy for one cycle: the transmitter raises it late
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      first_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state_q)
        T_IDLE: if (pop) begin
          tx_data_q  <= mem_q[rd_q];
          tx_start_q <= 1'b1;
          first_q    <= 1'b1;
          tx_state_q <= T_WAIT;
        end
        T_WAIT: begin
          if (first_q)           first_q    <= 1'b0;
          else if (!bus.tx_busy) tx_state_q <= T_IDLE;
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bcd_out      = bcd_q;
  assign bcd_valid    = bcd_valid_q;
  assign err          = err_q;
  assign tx_drop      = tx_drop_q;
endmodule

// File: tb/tb_uart_bcd_parser.sv
// Scoreboard bench: stimulus pushes expected TX bytes and commit/error events,
// a negedge monitor pops and compares whenever the parser presents output.
module tb_uart_bcd_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] bcd_out;
  logic        bcd_valid, err, tx_drop;
  logic        force_busy = 1'b0;
  int          busy_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  tx_q [$];
  logic [24:0] ev_q [$];   // bit 24 set = error event, else commit value
  logic        prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_bcd_parser_if bus();

  uart_bcd_parser #(.DIGITS(6), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .err       (err),
    .tx_drop   (tx_drop)
  );

  // transmitter: busy from the cycle after tx_start for 10 cycles
  always @(posedge clk) begin
    if (bus.tx_start)      busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = force_busy || (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.tx_start) begin
        check("tx_start_gap", {31'd0, prev_start}, 32'd0);
        if (tx_q.size() == 0) unexpected("tx_unexpected", {24'd0, bus.tx_data});
        else check("tx_data", {24'd0, bus.tx_data}, {24'd0, tx_q.pop_front()});
      end
      prev_start = bus.tx_start;
      if (bcd_valid) begin
        if (ev_q.size() == 0) unexpected("bcd_valid_unexpected", {8'd0, bcd_out});
        else begin
          logic [24:0] e;
          e = ev_q.pop_front();
          check("commit_kind", {31'd0, e[24]}, 32'd0);
          check("bcd_out_commit", {8'd0, bcd_out}, {8'd0, e[23:0]});
        end
      end
      if (err) begin
        if (ev_q.size() == 0) unexpected("err_unexpected", 32'd1);
        else begin
          logic [24:0] e;
          e = ev_q.pop_front();
          check("err_kind", {31'd0, e[24]}, 32'd1);
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic exp_tx(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || ev_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, n >= 3000}, 32'd0);
    repeat (15) @(negedge clk);
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bcd_out",   {8'd0, bcd_out}, 32'd0);
    check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    check("rst_err",       {31'd0, err}, 32'd0);
    check("rst_tx_start",  {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data",   {24'd0, bus.tx_data}, 32'd0);
    check("rst_tx_drop",   {31'd0, tx_drop}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // full-width line
    exp_tx("123456K");
    ev_q.push_back({1'b0, 24'h123456});
    send_str("123456", 14);
    send(8'h0D);
    drain("drain_t1");
    check("t1_bcd_hold", {8'd0, bcd_out}, 32'h123456);

    // short line right-aligned, LF after CR silent
    exp_tx("42K");
    ev_q.push_back({1'b0, 24'h000042});
    send_str("42", 14);
    send(8'h0D);
    check("t2_valid_latency", {31'd0, bcd_valid}, 32'd1);
    check("t2_bcd_out", {8'd0, bcd_out}, 32'h000042);
    send(8'h0A);
    check("t2_lf_no_valid", {31'd0, bcd_valid}, 32'd0);
    check("t2_lf_no_err", {31'd0, err}, 32'd0);
    drain("drain_t2");

    // overlong line
    exp_tx("123456?");
    ev_q.push_back({1'b1, 24'h0});
    send_str("1234567", 14);
    send(8'h0D);
    check("t3_err_latency", {31'd0, err}, 32'd1);
    drain("drain_t3");
    check("t3_bcd_kept", {8'd0, bcd_out}, 32'h000042);

    // backspace editing
    exp_tx("12");
    tx_q.push_back(8'h08);
    exp_tx("9K");
    ev_q.push_back({1'b0, 24'h000019});
    send_str("12", 14);
    send(8'h08);
    repeat (14) @(negedge clk);
    send_str("9", 14);
    send(8'h0D);
    drain("drain_t4");

    // FIFO overflow while transmitter stalled
    check("t5_drop_before", {31'd0, tx_drop}, 32'd0);
    force_busy = 1'b1;
    exp_tx("1234");
    send_str("123456", 0);
    repeat (3) @(negedge clk);
    check("t5_drop_after", {31'd0, tx_drop}, 32'd1);
    force_busy = 1'b0;
    drain("drain_t5");
    send(8'h1B);
    repeat (3) @(negedge clk);
    check("t5_drop_sticky", {31'd0, tx_drop}, 32'd1);

    // bad character after a digit
    exp_tx("1?");
    ev_q.push_back({1'b1, 24'h0});
    send_str("1A", 14);
    send(8'h0D);
    drain("drain_t6a");

    // bad character first: the later digit is not echoed
    exp_tx("?");
    ev_q.push_back({1'b1, 24'h0});
    send_str("A1", 14);
    send(8'h0D);
    drain("drain_t6b");
    check("t6_bcd_kept", {8'd0, bcd_out}, 32'h000019);

    // ESC clears, then a clean line
    exp_tx("7K");
    ev_q.push_back({1'b0, 24'h000007});
    send(8'h1B);
    repeat (3) @(negedge clk);
    send_str("7", 14);
    send(8'h0D);
    drain("drain_t7");
    check("t7_bcd_out", {8'd0, bcd_out}, 32'h000007);

    // reset mid-line with echoes pending: everything is discarded
    force_busy = 1'b1;
    send_str("55", 0);
    rst = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_bcd_out", {8'd0, bcd_out}, 32'd0);
    check("rst2_tx_drop", {31'd0, tx_drop}, 32'd0);
    check("rst2_tx_start", {31'd0, bus.tx_start}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h0D);
    repeat (14) @(negedge clk);
    exp_tx("8K");
    ev_q.push_back({1'b0, 24'h000008});
    send_str("8", 14);
    send(8'h0D);
    drain("drain_t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
